serial_addsub: RTL and testbench
================================

Name: serial_addsub

Overview:
- Parametrised, chunk-serial adder/subtractor: the multi-cycle successor to the team's fixed 4-bit ripple adder.
- Adds or subtracts two WIDTH-bit operands, CHUNK bits per clock, through one small CHUNK-bit ripple adder.
- Uses a START/BUSY/DONE handshake and produces carry/borrow and signed-overflow flags.
- Sits in the datapath wherever a wide add is needed and area matters more than latency.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits processed per clock; 1 <= CHUNK <= WIDTH.
- Derived: NCHUNK = WIDTH/CHUNK, the number of RUN cycles.

Ports:
- CLK  in  1  Rising-edge clock.
- RST_N  in  1  Asynchronous, active-low reset.
- START  in  1  Request; accepted on a rising edge when BUSY=0.
- SUB  in  1  0 = A+B+CIN; 1 = A-B (A + ~B + 1; CIN ignored). Sampled on accept.
- A  in  WIDTH  Operand A, sampled on accept.
- B  in  WIDTH  Operand B, sampled on accept.
- CIN  in  1  Carry-in for add mode, sampled on accept.
- BUSY  out  1  High while state is RUN.
- DONE  out  1  One-cycle pulse when the result becomes valid.
- SUM  out  WIDTH  Result; updated only together with DONE, held otherwise.
- CARRY  out  1  Carry out of the MSB. In SUB mode, 1 = no borrow.
- OVF  out  1  Two's-complement signed overflow.

Behaviour:
- Reset (async assert, sync release):
  - state IDLE.
  - BUSY=0, DONE=0, SUM=0, CARRY=0, OVF=0.
  - Internal operand/result registers and chunk counter cleared.
- States: IDLE, RUN, FIN.
  - BUSY=0 in IDLE and FIN.
  - DONE=1 only in FIN.
- IDLE or FIN, START=1 at an edge:
  - latch opA=A and opB = SUB ? ~B : B.
  - carry reg = SUB ? 1 : CIN.
  - idx=0.
  - go to RUN.
- IDLE, START=0: stay in IDLE.
- FIN, START=0: go to IDLE.
- START while BUSY=1 is ignored; the in-flight operation is unaffected.
- RUN, each edge:
  - compute chunk idx: opA[idx] + opB[idx] + carry reg.
  - write it into result chunk idx.
  - update carry reg; idx++.
- RUN, on the edge processing idx = NCHUNK-1:
  - SUM = full result; CARRY = final carry.
  - OVF = (opA[MSB] == opB[MSB]) && (result[MSB] != opA[MSB]), using the post-inversion opB.
  - go to FIN.
- Latency: DONE is high in the cycle after the NCHUNK-th edge following the accept edge.
  - Back-to-back throughput: one result per NCHUNK+1 cycles.
- SUM/CARRY/OVF keep their values through IDLE and subsequent RUN until the next FIN.
- NCHUNK=1 (CHUNK=WIDTH): one RUN cycle, then FIN.
- Reset asserted mid-RUN:
  - immediate return to reset values.
  - no DONE pulse; the partial result is discarded.
- Operand changes on A/B/SUB/CIN after accept have no effect.
- Elaboration error if WIDTH % CHUNK != 0 or CHUNK < 1.

Decomposition:
- Shared package holds the state encoding constants (IDLE, RUN, FIN), 2-bit.
- Sub-module adder_nbit: a parametrised CHUNK-bit combinational ripple adder with A, B, CIN, SUM, CARRY.
  - Built from the existing full-adder cell in a generate loop.
  - Instantiated once.
- Counter width is clog2(NCHUNK), minimum 1.

Test Plan (WIDTH=16, CHUNK=4):
- Reset: drive RST_N=0 mid-cycle -> BUSY, DONE, SUM, CARRY, OVF all 0 asynchronously. After release, BUSY stays 0 with no START.
- Add: A=0x1234, B=0x0FFF, CIN=0, SUB=0 -> BUSY high 4 cycles, then DONE pulses 1 cycle with SUM=0x2233, CARRY=0, OVF=0.
- Cross-chunk ripple: A=0xFFFF, B=0x0000, CIN=1 -> SUM=0x0000, CARRY=1, OVF=0.
- Signed overflow: A=0x7FFF, B=0x0001, CIN=0 -> SUM=0x8000, CARRY=0, OVF=1.
- Subtract with borrow: SUB=1, A=0x0005, B=0x0007, CIN=1 (must be ignored) -> SUM=0xFFFE, CARRY=0, OVF=0.
- Handshake: START pulsed during BUSY -> ignored, only one DONE. START held in the FIN cycle -> new op accepted with no IDLE gap. RST_N low at RUN cycle 2 -> no DONE, SUM stays 0.

Source files
------------

// File: rtl/serial_addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_addsub_pkg
// Description : Shared definitions for the chunk-serial adder/subtractor.
//               Holds the 2-bit controller state encoding and a helper that
//               sizes the chunk counter (never narrower than one bit).
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package serial_addsub_pkg;

  // Controller state encoding
  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_run  = 2'd1;
  localparam logic [1:0] c_st_fin  = 2'd2;

  // Width of a counter able to hold 0..n-1; a single-chunk datapath still
  // gets a 1-bit counter so the port/register never collapses to zero width.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage : serial_addsub_pkg
`default_nettype wire

// File: rtl/adder_nbit.sv
`default_nettype none
// ============================================================================
// Module      : adder_nbit
// Description : Parametrised N-bit combinational ripple-carry adder built as
//               a chain of full_adder cells.
// Ports       : a, b   [N-1:0] - addends
//               cin            - carry into bit 0
//               sum  [N-1:0]   - sum
//               carry          - carry out of bit N-1
// Revision    : 1.0 - initial release
// ============================================================================
module adder_nbit #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         carry
);

  logic [N:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (w_c[i]),
      .sum  (sum[i]),
      .cout (w_c[i+1])
    );
  end

  assign carry = w_c[N];

endmodule : adder_nbit
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module      : full_adder
// Description : Single-bit full adder cell.
// Ports       : a, b, cin  - addend bits and carry in
//               sum, cout  - sum bit and carry out
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule : full_adder
`default_nettype wire

// File: rtl/serial_addsub.sv
`default_nettype none
// ============================================================================
// Module      : serial_addsub
// Description : Chunk-serial adder/subtractor. Processes a WIDTH-bit add or
//               subtract CHUNK bits per clock through a single CHUNK-bit
//               ripple adder, with a START/BUSY/DONE handshake and
//               carry/borrow plus signed-overflow flags.
// Ports       : clk             - rising-edge clock
//               rst_n           - asynchronous active-low reset
//               start           - request, accepted when busy is low
//               sub             - 0: a+b+cin, 1: a-b (cin ignored)
//               a, b  [WIDTH]   - operands, sampled on accept
//               cin             - carry in for add mode, sampled on accept
//               busy            - high while the operation is running
//               done            - one-cycle pulse when the result is valid
//               sum   [WIDTH]   - result, updated only with done
//               carry           - carry out of MSB (sub: 1 = no borrow)
//               ovf             - two's-complement signed overflow
// Revision    : 1.0 - initial release
// ============================================================================
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);

  localparam int NCHUNK = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
  localparam int CW     = cnt_width(NCHUNK);
  localparam logic [CW-1:0] c_last_idx = CW'(NCHUNK - 1);

  if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % ((CHUNK > 0) ? CHUNK : 1)) != 0))
  begin : g_bad_params
    $error("serial_addsub: WIDTH (%0d) must be a positive multiple of CHUNK (%0d)",
           WIDTH, CHUNK);
  end

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CW-1:0]    r_idx;

  logic [CHUNK-1:0] w_ac;
  logic [CHUNK-1:0] w_bc;
  logic [CHUNK-1:0] w_s;
  logic             w_co;
  logic [WIDTH-1:0] w_res_next;
  logic             w_accept;
  logic             w_last;

  // Operands are shifted right one chunk per RUN cycle, so the chunk being
  // processed always sits in the low bits; no variable part-select is needed.
  // On the last chunk the low bits therefore hold the operand MSBs.
  assign w_ac = r_opa[CHUNK-1:0];
  assign w_bc = r_opb[CHUNK-1:0];

  adder_nbit #(
    .N (CHUNK)
  ) u_adder (
    .a     (w_ac),
    .b     (w_bc),
    .cin   (r_carry),
    .sum   (w_s),
    .carry (w_co)
  );

  // The result is assembled from the top down: each new chunk enters at the
  // MSB end and earlier chunks move one chunk lower. After NCHUNK steps the
  // first chunk has arrived at bit 0.
  always_comb begin
    w_res_next                    = r_res >> CHUNK;
    w_res_next[WIDTH-1 -: CHUNK]  = w_s;
  end

  assign w_accept = start && (r_state != c_st_run);
  assign w_last   = (r_idx == c_last_idx);

  assign busy = (r_state == c_st_run);
  assign done = (r_state == c_st_fin);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
      r_opa   <= '0;
      r_opb   <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      sum     <= '0;
      carry   <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle, c_st_fin: begin
          if (w_accept) begin
            r_opa   <= a;
            // Subtract is a + ~b + 1: invert b here and force carry in.
            r_opb   <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_idx   <= '0;
            r_state <= c_st_run;
          end else begin
            r_state <= c_st_idle;
          end
        end

        c_st_run: begin
          r_opa   <= r_opa >> CHUNK;
          r_opb   <= r_opb >> CHUNK;
          r_res   <= w_res_next;
          r_carry <= w_co;
          r_idx   <= r_idx + 1'b1;
          if (w_last) begin
            sum     <= w_res_next;
            carry   <= w_co;
            // Overflow uses the post-inversion b operand's sign bit.
            ovf     <= (w_ac[CHUNK-1] == w_bc[CHUNK-1]) &&
                       (w_s[CHUNK-1] != w_ac[CHUNK-1]);
            r_state <= c_st_fin;
          end
        end

        default: r_state <= c_st_idle;
      endcase
    end
  end

endmodule : serial_addsub
`default_nettype wire

// File: tb/tb_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_addsub
// Description : Self-checking bench for serial_addsub (WIDTH=16, CHUNK=4).
//               Directed cases plus randomized operations compared against
//               an integer-arithmetic reference model.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_addsub;

  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             sub   = 1'b0;
  logic [WIDTH-1:0] a     = '0;
  logic [WIDTH-1:0] b     = '0;
  logic             cin   = 1'b0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             ovf;

  int n_vec = 0;
  int n_bad = 0;

  serial_addsub #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .carry (carry),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic. Returns {ovf, carry, sum}.
  function automatic logic [17:0] model(input logic s, input logic [15:0] x,
                                        input logic [15:0] y, input logic ci);
    int          sx, sy, sr, cii;
    int unsigned ux, uy, ur;
    logic        c, o;
    sx  = $signed(x);
    sy  = $signed(y);
    ux  = x;
    uy  = y;
    cii = ci;
    if (s) begin
      sr = sx - sy;
      ur = ux - uy;
      c  = (ux >= uy);
    end else begin
      sr = sx + sy + cii;
      ur = ux + uy + cii;
      c  = ur[16];
    end
    o = (sr > 32767) || (sr < -32768);
    return {o, c, ur[15:0]};
  endfunction

  // Called at a negedge: presents a request, lets the next posedge accept
  // it, then scrambles the inputs (they must no longer matter).
  task automatic issue(input logic s, input logic [15:0] x, input logic [15:0] y,
                       input logic ci);
    start = 1'b1;
    sub   = s;
    a     = x;
    b     = y;
    cin   = ci;
    @(negedge clk);
    start = 1'b0;
    a     = 16'($urandom);
    b     = 16'($urandom);
    sub   = 1'($urandom);
    cin   = 1'($urandom);
  endtask

  // Waits (bounded) for done; returns at the negedge where done is seen.
  task automatic wait_result(input string tag, input int exp_lat,
                             input logic [15:0] es, input logic ec, input logic eo);
    int lat = 0;
    int nb  = 0;
    while (!done && lat < 4 * NCHUNK + 4) begin
      if (busy) nb++;
      lat++;
      @(negedge clk);
    end
    check({tag, "/latency"}, lat, exp_lat);
    check({tag, "/busy_cycles"}, nb, exp_lat);
    check({tag, "/done"}, {31'd0, done}, 32'd1);
    check({tag, "/busy_in_fin"}, {31'd0, busy}, 32'd0);
    check({tag, "/sum"}, {16'd0, sum}, {16'd0, es});
    check({tag, "/carry"}, {31'd0, carry}, {31'd0, ec});
    check({tag, "/ovf"}, {31'd0, ovf}, {31'd0, eo});
  endtask

  task automatic idle_check(input string tag, input logic [15:0] es);
    @(negedge clk);
    check({tag, "/done_dropped"}, {31'd0, done}, 32'd0);
    check({tag, "/idle_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "/sum_held"}, {16'd0, sum}, {16'd0, es});
  endtask

  task automatic directed(input string tag, input logic s, input logic [15:0] x,
                          input logic [15:0] y, input logic ci,
                          input logic [15:0] es, input logic ec, input logic eo);
    issue(s, x, y, ci);
    wait_result(tag, NCHUNK, es, ec, eo);
    idle_check(tag, es);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [17:0] e;
    logic [17:0] e2;
    logic        seen_done;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst/busy",  {31'd0, busy},  32'd0);
    check("rst/done",  {31'd0, done},  32'd0);
    check("rst/sum",   {16'd0, sum},   32'd0);
    check("rst/carry", {31'd0, carry}, 32'd0);
    check("rst/ovf",   {31'd0, ovf},   32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst/busy", {31'd0, busy}, 32'd0);
    check("post_rst/done", {31'd0, done}, 32'd0);

    // Reset asserted in RUN cycle 2, between clock edges
    issue(1'b0, 16'h1234, 16'h1111, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst/busy", {31'd0, busy}, 32'd0);
    check("midrst/done", {31'd0, done}, 32'd0);
    check("midrst/sum",  {16'd0, sum},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen_done = seen_done | done;
    end
    check("midrst/no_done",   {31'd0, seen_done}, 32'd0);
    check("midrst/sum_after", {16'd0, sum},       32'd0);

    // Directed functional cases
    directed("add",     1'b0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
    directed("ripple",  1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    directed("sovf",    1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed("sub_brw", 1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    directed("sub_min", 1'b1, 16'h0000, 16'h8000, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed("neg_ovf", 1'b0, 16'h8000, 16'h8001, 1'b0, 16'h0001, 1'b1, 1'b1);

    // START pulsed while busy must be ignored
    issue(1'b0, 16'h0101, 16'h0202, 1'b0);
    start = 1'b1;
    a     = 16'hFFFF;
    b     = 16'hFFFF;
    @(negedge clk);
    start = 1'b0;
    wait_result("busy_start", NCHUNK - 1, 16'h0303, 1'b0, 1'b0);
    idle_check("busy_start", 16'h0303);

    // START held in FIN: accepted with no IDLE gap
    issue(1'b0, 16'h0001, 16'h0002, 1'b0);
    wait_result("b2b_1", NCHUNK, 16'h0003, 1'b0, 1'b0);
    issue(1'b1, 16'h0010, 16'h0001, 1'b0);
    wait_result("b2b_2", NCHUNK, 16'h000F, 1'b1, 1'b0);
    idle_check("b2b_2", 16'h000F);

    // Randomized operations, mixing idle gaps and back-to-back issue
    for (int i = 0; i < 40; i++) begin
      logic        rs, rc;
      logic [15:0] ra, rb;
      rs = 1'($urandom);
      rc = 1'($urandom);
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 3) == 0) ra = 16'h7FFF + 16'($urandom_range(0, 2));
      e = model(rs, ra, rb, rc);
      issue(rs, ra, rb, rc);
      wait_result($sformatf("rnd%0d", i), NCHUNK, e[15:0], e[16], e[17]);
      if ($urandom_range(0, 1) == 1) idle_check($sformatf("rnd%0d", i), e[15:0]);
    end

    // Async reset clears non-zero flags/result without a clock edge
    e2 = model(1'b0, 16'h8000, 16'h8001, 1'b0);
    issue(1'b0, 16'h8000, 16'h8001, 1'b0);
    wait_result("pre_rst", NCHUNK, e2[15:0], e2[16], e2[17]);
    idle_check("pre_rst", e2[15:0]);
    issue(1'b0, 16'h1111, 16'h2222, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rst2/busy",  {31'd0, busy},  32'd0);
    check("rst2/sum",   {16'd0, sum},   32'd0);
    check("rst2/carry", {31'd0, carry}, 32'd0);
    check("rst2/ovf",   {31'd0, ovf},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_serial_addsub
`default_nettype wire
